clq_multiport: RTL and testbench

Parametrised clause-list queue for the lookup stage. Holds the clause-node buffer and per-literal dummy-head table that the clause arbiter loads, and serves NUM_PORTS independent BCP engines. Each engine gets a registered unit-literal head lookup channel with valid/ready backpressure and an asynchronous node read port. A two-state load/run controller separates loading from lookup and adds clear, full and error reporting.

---
 rtl/clq_multiport.sv | 201 ++++++++++++++++++++
 tb/tb_clq_multiport.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clq_multiport.sv
// ---------------------------------------------------------------------------
// clq_multiport
//
// Clause-list queue for the lookup stage. The clause arbiter loads a node
// buffer (append-only) and a per-literal dummy-head table while in LOAD.
// After load_done the queue enters RUN and serves NUM_PORTS independent BCP
// engines. Each engine has a registered head-lookup channel and an
// asynchronous node read port.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   push, push_node     append a node at the tail (LOAD only)
//   head_we, head_idx,  write head table entry {head_null, head_ptr}
//   head_null, head_ptr   (LOAD only)
//   load_done           LOAD -> RUN
//   clear               empty the queue, drop responses, return to LOAD
//   req_valid/req_lit/  per-port lookup request channel
//   req_ready
//   rsp_valid/rsp_ready per-port lookup response channel
//   rsp_hit/rsp_ptr
//   node_idx/node_out   per-port combinational node read
//   running             controller is in RUN (this is the FSM state)
//   count, full         nodes stored, count == DEPTH
//   err                 sticky protocol error (cleared by clear/reset)
//
// Handshake: a channel beat transfers on a rising clk edge where valid and
// ready are both high. valid must not depend on ready. The response side
// holds rsp_valid and its data stable until rsp_ready is seen high.
// ---------------------------------------------------------------------------
module clq_multiport #(
  parameter int DEPTH       = 16,
  parameter int LIT_IDX_MAX = 16,
  parameter int NODE_W      = 32,
  parameter int NUM_PORTS   = 2,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LIT_W  = $clog2(LIT_IDX_MAX) + 1,
  localparam int HIDX_W = $clog2(2 * LIT_IDX_MAX)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push,
  input  logic [NODE_W-1:0]             push_node,
  input  logic                          head_we,
  input  logic [HIDX_W-1:0]             head_idx,
  input  logic                          head_null,
  input  logic [PTR_W-1:0]              head_ptr,
  input  logic                          load_done,
  input  logic                          clear,
  input  logic [NUM_PORTS-1:0]          req_valid,
  input  logic [NUM_PORTS*LIT_W-1:0]    req_lit,
  output logic [NUM_PORTS-1:0]          req_ready,
  output logic [NUM_PORTS-1:0]          rsp_valid,
  input  logic [NUM_PORTS-1:0]          rsp_ready,
  output logic [NUM_PORTS-1:0]          rsp_hit,
  output logic [NUM_PORTS*PTR_W-1:0]    rsp_ptr,
  input  logic [NUM_PORTS*PTR_W-1:0]    node_idx,
  output logic [NUM_PORTS*NODE_W-1:0]   node_out,
  output logic                          running,
  output logic [PTR_W:0]                count,
  output logic                          full,
  output logic                          err
);

  localparam int HEADS = 2 * LIT_IDX_MAX;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [NODE_W-1:0] buf_mem   [DEPTH];
  logic              head_nul_q [HEADS];
  logic [PTR_W-1:0]  head_ptr_q [HEADS];
  logic [PTR_W:0]    count_q;
  logic              err_q;

  logic [NUM_PORTS-1:0]       rsp_valid_q;
  logic [NUM_PORTS-1:0]       rsp_hit_q;
  logic [NUM_PORTS*PTR_W-1:0] rsp_ptr_q;

  logic [NUM_PORTS-1:0]       accept;
  logic [NUM_PORTS-1:0]       lk_hit;
  logic [NUM_PORTS*PTR_W-1:0] lk_ptr;
  logic [LIT_W-1:0]           lk_lit;
  logic [LIT_W-2:0]           lk_mag;
  logic [HIDX_W-1:0]          lk_idx;

  logic push_ok;
  logic push_bad;
  logic head_bad;

  // ---------------- controller ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_LOAD;
    else        state_q <= state_d;
  end

  // clear always wins over load_done.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: if (clear) state_d = ST_LOAD;
               else if (load_done) state_d = ST_RUN;
      ST_RUN:  if (clear) state_d = ST_LOAD;
      default: state_d = ST_LOAD;
    endcase
  end

  assign running = (state_q == ST_RUN);
  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign count   = count_q;
  assign err     = err_q;

  assign push_ok  = push & ~running & ~full;
  assign push_bad = push & (running | full);
  assign head_bad = head_we & running;

  // ---------------- lookup ----------------
  assign req_ready = {NUM_PORTS{running}} & (~rsp_valid_q | rsp_ready);
  // A request presented in a clear cycle never produces a response.
  assign accept    = req_valid & req_ready & ~{NUM_PORTS{clear}};

  // Magnitude is taken on the low LIT_W-1 bits only: both 0 and the
  // most-negative code map to magnitude 0, which is the miss case.
  // Negative literals land in the upper half of the table, so the table
  // index is simply {sign, magnitude}.
  always_comb begin
    lk_hit = '0;
    lk_ptr = '0;
    lk_lit = '0;
    lk_mag = '0;
    lk_idx = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      lk_lit = req_lit[p*LIT_W +: LIT_W];
      lk_mag = lk_lit[LIT_W-1] ? (~lk_lit[LIT_W-2:0] + (LIT_W-1)'(1))
                               : lk_lit[LIT_W-2:0];
      lk_idx = HIDX_W'({lk_lit[LIT_W-1], lk_mag});
      lk_hit[p] = (lk_mag != '0) && !head_nul_q[lk_idx];
      lk_ptr[p*PTR_W +: PTR_W] = lk_hit[p] ? head_ptr_q[lk_idx] : '0;
    end
  end

  // ---------------- storage and response registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      rsp_hit_q   <= '0;
      rsp_ptr_q   <= '0;
      for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
      for (int i = 0; i < HEADS; i++) begin
        head_nul_q[i] <= 1'b1;
        head_ptr_q[i] <= '0;
      end
    end else if (clear) begin
      // Buffer contents are left in place; only the tail is rewound.
      count_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= '0;
      for (int i = 0; i < HEADS; i++) begin
        head_nul_q[i] <= 1'b1;
        head_ptr_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        buf_mem[count_q[PTR_W-1:0]] <= push_node;
        count_q <= count_q + (PTR_W+1)'(1);
      end
      if (head_we && !running) begin
        head_nul_q[head_idx] <= head_null;
        head_ptr_q[head_idx] <= head_ptr;
      end
      if (push_bad || head_bad) err_q <= 1'b1;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (accept[p]) begin
          rsp_valid_q[p]             <= 1'b1;
          rsp_hit_q[p]               <= lk_hit[p];
          rsp_ptr_q[p*PTR_W +: PTR_W] <= lk_ptr[p*PTR_W +: PTR_W];
        end else if (rsp_ready[p]) begin
          rsp_valid_q[p] <= 1'b0;
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_ptr   = rsp_ptr_q;

  // ---------------- node read ports ----------------
  always_comb begin
    node_out = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      node_out[p*NODE_W +: NODE_W] = buf_mem[node_idx[p*PTR_W +: PTR_W]];
    end
  end

endmodule

// File: tb/tb_clq_multiport.sv
module tb_clq_multiport;

  localparam int DEPTH       = 16;
  localparam int LIT_IDX_MAX = 16;
  localparam int NODE_W      = 32;
  localparam int NUM_PORTS   = 2;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LIT_W  = $clog2(LIT_IDX_MAX) + 1;
  localparam int HIDX_W = $clog2(2 * LIT_IDX_MAX);
  localparam int HEADS  = 2 * LIT_IDX_MAX;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                        push;
  logic [NODE_W-1:0]           push_node;
  logic                        head_we;
  logic [HIDX_W-1:0]           head_idx;
  logic                        head_null;
  logic [PTR_W-1:0]            head_ptr;
  logic                        load_done;
  logic                        clear;
  logic [NUM_PORTS-1:0]        req_valid;
  logic [NUM_PORTS*LIT_W-1:0]  req_lit;
  logic [NUM_PORTS-1:0]        req_ready;
  logic [NUM_PORTS-1:0]        rsp_valid;
  logic [NUM_PORTS-1:0]        rsp_ready;
  logic [NUM_PORTS-1:0]        rsp_hit;
  logic [NUM_PORTS*PTR_W-1:0]  rsp_ptr;
  logic [NUM_PORTS*PTR_W-1:0]  node_idx;
  logic [NUM_PORTS*NODE_W-1:0] node_out;
  logic                        running;
  logic [PTR_W:0]              count;
  logic                        full;
  logic                        err;

  clq_multiport #(
    .DEPTH(DEPTH), .LIT_IDX_MAX(LIT_IDX_MAX), .NODE_W(NODE_W), .NUM_PORTS(NUM_PORTS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .push(push), .push_node(push_node),
    .head_we(head_we), .head_idx(head_idx), .head_null(head_null), .head_ptr(head_ptr),
    .load_done(load_done), .clear(clear),
    .req_valid(req_valid), .req_lit(req_lit), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_ptr(rsp_ptr),
    .node_idx(node_idx), .node_out(node_out),
    .running(running), .count(count), .full(full), .err(err)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [PTR_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Behavioural view: an array of nodes plus a tail count, a literal-indexed
  // head table, a mode flag, a sticky error and one pending response per port.
  logic [NODE_W-1:0] m_buf [DEPTH];
  bit                m_null [HEADS];
  int                m_ptr  [HEADS];
  int                m_count;
  bit                m_run;
  bit                m_err;
  bit                m_v   [NUM_PORTS];
  bit                m_hit [NUM_PORTS];
  int                m_ptrv[NUM_PORTS];

  task automatic model_clear();
    m_count = 0; m_run = 0; m_err = 0;
    for (int i = 0; i < HEADS; i++) begin m_null[i] = 1; m_ptr[i] = 0; end
    for (int p = 0; p < NUM_PORTS; p++) m_v[p] = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_buf[i] = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin m_hit[p] = 0; m_ptrv[p] = 0; end
    model_clear();
  endtask

  // Literal l: +m -> entry m, -m -> entry m+LIT_IDX_MAX; 0 and -LIT_IDX_MAX miss.
  task automatic ref_lookup(input logic [LIT_W-1:0] lit, output bit hit, output int ptr);
    int l;
    int idx;
    l = int'($signed(lit));
    hit = 0; ptr = 0;
    if (l != 0 && l != -LIT_IDX_MAX) begin
      idx = (l > 0) ? l : (LIT_IDX_MAX - l);
      hit = !m_null[idx];
      ptr = hit ? m_ptr[idx] : 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    push = 0; head_we = 0; load_done = 0; clear = 0; req_valid = '0;
  endtask

  task automatic set_req(input int p, input bit v, input int lit);
    req_valid[p] = v;
    req_lit[p*LIT_W +: LIT_W] = LIT_W'(lit);
  endtask

  task automatic set_head(input int idx, input bit nul, input int ptr);
    head_we = 1; head_idx = HIDX_W'(idx); head_null = nul; head_ptr = PTR_W'(ptr);
  endtask

  // One clock with the currently driven inputs; every output is checked
  // against the model before and after the edge.
  task automatic step();
    logic [NUM_PORTS-1:0] exp_rdy;
    bit h;
    int pt;
    int idx;
    #1;
    for (int p = 0; p < NUM_PORTS; p++) exp_rdy[p] = m_run && (!m_v[p] || rsp_ready[p]);
    check("req_ready", 64'(req_ready), 64'(exp_rdy));
    for (int p = 0; p < NUM_PORTS; p++) begin
      idx = int'(node_idx[p*PTR_W +: PTR_W]);
      if (idx < m_count)
        check($sformatf("node_out[%0d]", p), 64'(node_out[p*NODE_W +: NODE_W]), 64'(m_buf[idx]));
    end
    if (clear) begin
      model_clear();
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (req_valid[p] && exp_rdy[p]) begin
          ref_lookup(req_lit[p*LIT_W +: LIT_W], h, pt);
          m_v[p] = 1; m_hit[p] = h; m_ptrv[p] = pt;
        end else if (rsp_ready[p]) begin
          m_v[p] = 0;
        end
      end
      if (push) begin
        if (m_run || m_count == DEPTH) m_err = 1;
        else begin m_buf[m_count] = push_node; m_count++; end
      end
      if (head_we) begin
        if (m_run) m_err = 1;
        else begin m_null[head_idx] = head_null; m_ptr[head_idx] = int'(head_ptr); end
      end
      if (!m_run && load_done) m_run = 1;
    end
    @(posedge clk); #1;
    check("running", 64'(running), 64'(m_run));
    check("count", 64'(count), 64'(m_count));
    check("full", 64'(full), 64'(m_count == DEPTH));
    check("err", 64'(err), 64'(m_err));
    for (int p = 0; p < NUM_PORTS; p++) begin
      check($sformatf("rsp_valid[%0d]", p), 64'(rsp_valid[p]), 64'(m_v[p]));
      if (m_v[p]) begin
        check($sformatf("rsp_hit[%0d]", p), 64'(rsp_hit[p]), 64'(m_hit[p]));
        check($sformatf("rsp_ptr[%0d]", p), 64'(rsp_ptr[p*PTR_W +: PTR_W]), 64'(m_ptrv[p]));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  typedef struct { int lit; bit hit; int ptr; } vec_t;
  vec_t vecs [10];

  initial begin
    vecs[0] = '{2, 1, 1};   vecs[1] = '{-2, 0, 0};  vecs[2] = '{3, 1, 2};
    vecs[3] = '{5, 1, 7};   vecs[4] = '{-4, 1, 9};  vecs[5] = '{0, 0, 0};
    vecs[6] = '{-16, 0, 0}; vecs[7] = '{15, 0, 0};  vecs[8] = '{-5, 0, 0};
    vecs[9] = '{1, 0, 0};

    rst_n = 0; idle(); push_node = '0; head_idx = '0; head_null = 0; head_ptr = '0;
    req_lit = '0; rsp_ready = '1; node_idx = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    model_reset();

    // reset state
    check("rst running", 64'(running), 0);
    check("rst count", 64'(count), 0);
    check("rst full", 64'(full), 0);
    check("rst err", 64'(err), 0);
    check("rst req_ready", 64'(req_ready), 0);
    check("rst rsp_valid", 64'(rsp_valid), 0);
    check("rst rsp_hit", 64'(rsp_hit), 0);
    check("rst rsp_ptr", 64'(rsp_ptr), 0);
    check("rst node_out", 64'(node_out[NODE_W-1:0]), 0);

    // load: pushes overlapped with head writes, one overwrite, one null entry
    push = 1; push_node = 'hA; set_head(3, 0, 5); step();
    push_node = 'hB; set_head(2, 0, 1); step();
    push_node = 'hC; set_head(3, 0, 2); step();
    push = 0; set_head(5, 0, 7); step();
    set_head(20, 0, 9); step();
    set_head(16, 0, 3); step();
    set_head(18, 1, 6); step();
    idle(); load_done = 1; step();
    idle();
    node_idx = {PTR_W'(2), PTR_W'(1)}; #1;
    check("load node_out idx1", 64'(node_out[NODE_W-1:0]), 'hB);
    check("load node_out idx2", 64'(node_out[2*NODE_W-1:NODE_W]), 'hC);
    check("load count", 64'(count), 3);
    check("load running", 64'(running), 1);

    // same-cycle lookups on both ports
    set_req(0, 1, 2); set_req(1, 1, -2); step();
    check("dual p0 hit", 64'(rsp_hit[0]), 1);
    check("dual p0 ptr", 64'(rsp_ptr[PTR_W-1:0]), 1);
    check("dual p1 hit", 64'(rsp_hit[1]), 0);
    check("dual p1 ptr", 64'(rsp_ptr[2*PTR_W-1:PTR_W]), 0);

    // table of literal mappings, both ports same literal, back-to-back
    for (int i = 0; i < 10; i++) begin
      set_req(0, 1, vecs[i].lit); set_req(1, 1, vecs[i].lit); step();
      for (int p = 0; p < NUM_PORTS; p++) begin
        check($sformatf("vec%0d valid p%0d", i, p), 64'(rsp_valid[p]), 1);
        check($sformatf("vec%0d hit p%0d", i, p), 64'(rsp_hit[p]), 64'(vecs[i].hit));
        check($sformatf("vec%0d ptr p%0d", i, p), 64'(rsp_ptr[p*PTR_W +: PTR_W]), 64'(vecs[i].ptr));
      end
    end
    idle(); step();

    // stall port0 for three cycles with a new request waiting
    rsp_ready = 2'b10; set_req(0, 1, 3); step();
    set_req(0, 1, 5);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall valid", 64'(rsp_valid[0]), 1);
      check("stall ptr", 64'(rsp_ptr[PTR_W-1:0]), 2);
      check("stall req_ready", 64'(req_ready[0]), 0);
    end
    // release: b2b +2,+3,+2 come back one per cycle in order
    rsp_ready = '1;
    exp_q.push_back(PTR_W'(1)); exp_q.push_back(PTR_W'(2)); exp_q.push_back(PTR_W'(1));
    set_req(0, 1, 2); step();
    check("b2b0 valid", 64'(rsp_valid[0]), 1);
    check("b2b0 ptr", 64'(rsp_ptr[PTR_W-1:0]), 64'(exp_q.pop_front()));
    set_req(0, 1, 3); step();
    check("b2b1 valid", 64'(rsp_valid[0]), 1);
    check("b2b1 ptr", 64'(rsp_ptr[PTR_W-1:0]), 64'(exp_q.pop_front()));
    set_req(0, 1, 2); step();
    check("b2b2 valid", 64'(rsp_valid[0]), 1);
    check("b2b2 ptr", 64'(rsp_ptr[PTR_W-1:0]), 64'(exp_q.pop_front()));
    idle(); step();

    // push and head write in RUN are both ignored and flag err
    push = 1; push_node = 'hDEAD; set_head(2, 1, 0); step();
    check("run push err", 64'(err), 1);
    check("run push count", 64'(count), 3);
    idle(); set_req(0, 1, 2); step();
    check("run headwe ignored hit", 64'(rsp_hit[0]), 1);
    check("run headwe ignored ptr", 64'(rsp_ptr[PTR_W-1:0]), 1);

    // randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      idle();
      for (int p = 0; p < NUM_PORTS; p++) begin
        set_req(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, HEADS - 1)));
        node_idx[p*PTR_W +: PTR_W] = PTR_W'($urandom_range(0, DEPTH - 1));
      end
      rsp_ready = NUM_PORTS'($urandom);
      step();
    end
    rsp_ready = '1;

    // clear from RUN
    idle(); clear = 1; step();
    check("clear running", 64'(running), 0);
    check("clear count", 64'(count), 0);
    check("clear err", 64'(err), 0);
    check("clear rsp_valid", 64'(rsp_valid), 0);

    // fill past DEPTH
    for (int i = 0; i < DEPTH + 1; i++) begin
      idle(); push = 1; push_node = $urandom; step();
      if (i == DEPTH - 1) begin
        check("fill full", 64'(full), 1);
        check("fill err before overflow", 64'(err), 0);
      end
    end
    check("overflow full", 64'(full), 1);
    check("overflow count", 64'(count), DEPTH);
    check("overflow err", 64'(err), 1);
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      node_idx[PTR_W-1:0] = PTR_W'(i); #1;
      check($sformatf("buf[%0d]", i), 64'(node_out[NODE_W-1:0]), 64'(m_buf[i]));
    end

    // reload without head writes: +2 now misses
    load_done = 1; step();
    idle(); set_req(0, 1, 2); set_req(1, 1, 2); step();
    check("reload p0 hit", 64'(rsp_hit[0]), 0);
    check("reload p1 hit", 64'(rsp_hit[1]), 0);
    check("reload p0 ptr", 64'(rsp_ptr[PTR_W-1:0]), 0);

    // clear + load_done with a response pending: clear wins, response dropped
    idle(); rsp_ready = 2'b10; set_req(0, 1, 3); step();
    check("pend valid", 64'(rsp_valid[0]), 1);
    clear = 1; load_done = 1; set_req(0, 1, 2); set_req(1, 1, 2); step();
    check("clr+done running", 64'(running), 0);
    check("clr+done rsp_valid", 64'(rsp_valid), 0);
    idle(); rsp_ready = '1; step();
    check("clr+done stays load", 64'(running), 0);
    check("clr+done no rsp", 64'(rsp_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
